sw_debounce_sync: RTL and testbench

//  Conditions raw board slide-switch / push-button levels before the HPS

---
 rtl/sw_debounce_sync.sv | 89 ++++++++
 tb/tb_sw_debounce_sync.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sw_debounce_sync.sv
// Switch/button conditioner: per-bit 2-FF synchronizer followed by a per-bit debounce counter.
// Optional sticky event latch per bit, enabled by defining SW_DEBOUNCE_STICKY_EN.
module sw_debounce_sync #(
  parameter int               WIDTH           = 8,
  parameter int               DEBOUNCE_CYCLES = 500000,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_changed
`ifdef SW_DEBOUNCE_STICKY_EN
  ,
  input  logic [WIDTH-1:0] event_clr,
  output logic [WIDTH-1:0] sw_event
`endif
);

  localparam int CLOG_CYC = $clog2(DEBOUNCE_CYCLES);
  localparam int CNT_W    = (CLOG_CYC < 1) ? 1 : CLOG_CYC;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]            sync1_q, sync1_d;
  logic [WIDTH-1:0]            sync2_q, sync2_d;
  logic [WIDTH-1:0]            stable_q, stable_d;
  logic [WIDTH-1:0]            changed_q, changed_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

  // A single cycle where the synchronized level matches the accepted level
  // restarts the window, so bounces shorter than the window never propagate.
  always_comb begin
    sync1_d   = sw_raw;
    sync2_d   = sync1_q;
    stable_d  = stable_q;
    changed_d = '0;
    cnt_d     = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i]  = sync2_q[i];
        cnt_d[i]     = '0;
        changed_d[i] = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= RESET_VALUE;
      sync2_q   <= RESET_VALUE;
      stable_q  <= RESET_VALUE;
      changed_q <= '0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      stable_q  <= stable_d;
      changed_q <= changed_d;
      cnt_q     <= cnt_d;
    end
  end

  assign sw_stable  = stable_q;
  assign sw_changed = changed_q;

`ifdef SW_DEBOUNCE_STICKY_EN
  logic [WIDTH-1:0] event_q, event_d;

  // Set takes priority so a clear landing on a fresh transition cannot lose it.
  always_comb begin
    event_d = (event_q & ~event_clr) | changed_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      event_q <= '0;
    end else begin
      event_q <= event_d;
    end
  end

  assign sw_event = event_q;
`endif

endmodule

// File: tb/tb_sw_debounce_sync.sv
// Directed bench for sw_debounce_sync with DEBOUNCE_CYCLES=4, WIDTH=8, RESET_VALUE=0.
// Sticky-event scenarios are included when SW_DEBOUNCE_STICKY_EN is defined.
module tb_sw_debounce_sync;

  logic       clk;
  logic       reset_n;
  logic [7:0] sw_raw;
  logic [7:0] sw_stable;
  logic [7:0] sw_changed;
`ifdef SW_DEBOUNCE_STICKY_EN
  logic [7:0] event_clr;
  logic [7:0] sw_event;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  sw_debounce_sync #(
    .WIDTH          (8),
    .DEBOUNCE_CYCLES(4),
    .RESET_VALUE    (8'h00)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sw_raw    (sw_raw),
    .sw_stable (sw_stable),
    .sw_changed(sw_changed)
`ifdef SW_DEBOUNCE_STICKY_EN
    ,
    .event_clr (event_clr),
    .sw_event  (sw_event)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [7:0] raw);
    sw_raw  = raw;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    sw_raw  = 8'hFF;
`ifdef SW_DEBOUNCE_STICKY_EN
    event_clr = 8'h00;
`endif

    // 1: reset state, then full-window acceptance of FF
    #1;
    check("rst_stable_async", sw_stable, 8'h00);
    tick();
    tick();
    tick();
    check("rst_stable", sw_stable, 8'h00);
    check("rst_changed", sw_changed, 8'h00);
`ifdef SW_DEBOUNCE_STICKY_EN
    check("rst_event", sw_event, 8'h00);
`endif
    reset_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check("t1_stable", sw_stable, (k >= 6) ? 8'hFF : 8'h00);
      check("t1_changed", sw_changed, (k == 6) ? 8'hFF : 8'h00);
    end

    // 2: bit0 bounces, then settles low
    for (int j = 0; j < 10; j++) begin
      sw_raw[0] = (j % 2 == 0) ? 1'b1 : 1'b0;
      tick();
      check("t2_bounce_stable", sw_stable, 8'hFF);
      check("t2_bounce_changed", sw_changed, 8'h00);
    end
    for (int k = 2; k <= 7; k++) begin
      tick();
      check("t2_stable", sw_stable, (k >= 6) ? 8'hFE : 8'hFF);
      check("t2_changed", sw_changed, (k == 6) ? 8'h01 : 8'h00);
    end

    // 3: bit3 high for only 3 cycles is rejected
    do_reset(8'h00);
    tick();
    tick();
    sw_raw = 8'h08;
    tick();
    tick();
    tick();
    sw_raw = 8'h00;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("t3_stable", sw_stable, 8'h00);
      check("t3_changed", sw_changed, 8'h00);
    end

    // 4: bits 1 and 6 change together
    sw_raw = 8'h42;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check("t4_stable", sw_stable, (k >= 6) ? 8'h42 : 8'h00);
      check("t4_changed", sw_changed, (k == 6) ? 8'h42 : 8'h00);
    end

    // 5: reset during a pending bit5 rise
    sw_raw = 8'h62;
    tick();
    tick();
    check("t5_pending", sw_stable, 8'h42);
    reset_n = 1'b0;
    #1;
    check("t5_rst_stable", sw_stable, 8'h00);
    check("t5_rst_changed", sw_changed, 8'h00);
    tick();
    tick();
    check("t5_rst_hold", sw_stable, 8'h00);
    reset_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check("t5_stable", sw_stable, (k >= 6) ? 8'h62 : 8'h00);
      check("t5_changed", sw_changed, (k == 6) ? 8'h62 : 8'h00);
    end

`ifdef SW_DEBOUNCE_STICKY_EN
    // 6: sticky event set, clear, and set-wins coincidence on bit2
    check("t6_event_idle", sw_event, 8'h62);
    event_clr = 8'h62;
    tick();
    event_clr = 8'h00;
    check("t6_event_clr_init", sw_event, 8'h00);
    sw_raw = 8'h66;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("t6_event_set", sw_event, (k >= 6) ? 8'h04 : 8'h00);
    end
    event_clr = 8'h04;
    tick();
    event_clr = 8'h00;
    check("t6_event_cleared", sw_event, 8'h00);
    tick();
    check("t6_event_stays_clr", sw_event, 8'h00);
    sw_raw = 8'h62;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("t6_pre_coinc", sw_event, 8'h00);
    end
    event_clr = 8'h04;
    tick();
    event_clr = 8'h00;
    check("t6_coinc_changed", sw_changed, 8'h04);
    check("t6_coinc_event", sw_event, 8'h04);
    check("t6_coinc_stable", sw_stable, 8'h62);
    tick();
    check("t6_event_held", sw_event, 8'h04);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
